xor_mux_parity_pipe: RTL and testbench

//   Pipelined, parametrised parity generator whose every 2-input XOR is built from
//   mux instances (constants 0/1 and wires only), the successor of the single
//   mux-based XOR gate. It reduces a WIDTH-bit word to one parity bit through a

---
 rtl/xor_mux_parity_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_xor_mux_parity_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_mux_parity_pipe.sv
// xor_mux_parity_pipe: pipelined parity generator with valid/ready flow control.
//
// A WIDTH-bit word is reduced to one parity bit through a registered binary
// XOR tree of LVL = $clog2(WIDTH) levels, followed by one output register.
// Every 2-input XOR, the ODD inversion and the packet accumulator are built
// only from 2:1 mux cells fed by constants and wires.
//
// Latency: a word accepted on edge k shows up on down_* after edge k+LVL.
// All stages advance together when adv = ~down_valid | down_ready.
// Bubbles move through the pipeline like data and are not squeezed out.
//
// Optional feature, selected by the macro PARITY_ACC_EN (packet mode):
//   - A 1-bit accumulator follows the tree.
//   - Non-last words are folded into the accumulator and emit nothing.
//   - The last word emits acc XOR tree_out and clears the accumulator.
//   - Without the macro, every accepted word yields one result.
//
// Parameters:
//   WIDTH  input word width; must be a power of two, >= 2
//   ODD    0: even parity, 1: odd parity (inverted result)
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous reset, active-high
//   up_valid     input word valid
//   up_ready     block can accept a word this cycle
//   up_data      word to reduce
//   up_last      final word of a packet
//   down_valid   result valid
//   down_ready   consumer accepts the result
//   down_parity  parity result
//   down_last    up_last of the word(s) that produced this result

// 2:1 mux primitive: the only logic cell used by the parity datapath.
module xor_mux_parity_pipe_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module xor_mux_parity_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_parity,
    output logic             down_last
);
    localparam int unsigned LVL    = $clog2(WIDTH);
    localparam logic        OddSel = (ODD != 0);

    logic               adv;
    logic [WIDTH-2:0]   tree_d, tree_q;
    logic [2*WIDTH-2:0] node;
    logic [LVL-1:0]     vld_d, vld_q;
    logic [LVL-1:0]     lst_d, lst_q;
    logic               tree_out, tree_vld, tree_lst;
    logic               result, result_n, odd_out;
    logic               down_valid_d, down_valid_q;
    logic               down_parity_d, down_parity_q;
    logic               down_last_d, down_last_q;

    assign adv      = !down_valid_q || down_ready;
    assign up_ready = adv;

    // node[] holds the input word in its low WIDTH bits and the tree registers
    // above it, level by level, so level l reads from the slice level l-1 wrote.
    assign node = {tree_q, up_data};

    for (genvar l = 1; l <= LVL; l++) begin : g_lvl
        localparam int unsigned N   = WIDTH >> l;
        localparam int unsigned Src = 2 * WIDTH - 4 * N;
        localparam int unsigned Dst = WIDTH - 2 * N;
        for (genvar j = 0; j < N; j++) begin : g_cell
            logic a_n;
            // a XOR b = b ? ~a : a, with ~a taken from a constant-fed mux
            xor_mux_parity_pipe_mux2 u_inv (
                .d0  (1'b1),
                .d1  (1'b0),
                .sel (node[Src+2*j]),
                .y   (a_n)
            );
            xor_mux_parity_pipe_mux2 u_xor (
                .d0  (node[Src+2*j]),
                .d1  (a_n),
                .sel (node[Src+2*j+1]),
                .y   (tree_d[Dst+j])
            );
        end
    end

    // Valid and last bits travel alongside each tree level.
    always_comb begin
        vld_d    = vld_q;
        lst_d    = lst_q;
        vld_d[0] = up_valid;
        lst_d[0] = up_last;
        for (int unsigned i = 1; i < LVL; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tree_q <= '0;
            vld_q  <= '0;
            lst_q  <= '0;
        end else if (adv) begin
            tree_q <= tree_d;
            vld_q  <= vld_d;
            lst_q  <= lst_d;
        end
    end

    assign tree_out = tree_q[WIDTH-2];
    assign tree_vld = vld_q[LVL-1];
    assign tree_lst = lst_q[LVL-1];

`ifdef PARITY_ACC_EN
    logic acc_d, acc_q, acc_n, acc_x;

    xor_mux_parity_pipe_mux2 u_acc_inv (
        .d0  (1'b1),
        .d1  (1'b0),
        .sel (acc_q),
        .y   (acc_n)
    );
    xor_mux_parity_pipe_mux2 u_acc_xor (
        .d0  (acc_q),
        .d1  (acc_n),
        .sel (tree_out),
        .y   (acc_x)
    );
    assign result = acc_x;
`else
    assign result = tree_out;
`endif

    xor_mux_parity_pipe_mux2 u_res_inv (
        .d0  (1'b1),
        .d1  (1'b0),
        .sel (result),
        .y   (result_n)
    );
    xor_mux_parity_pipe_mux2 u_odd (
        .d0  (result),
        .d1  (result_n),
        .sel (OddSel),
        .y   (odd_out)
    );

    always_comb begin
        down_valid_d  = down_valid_q;
        down_parity_d = down_parity_q;
        down_last_d   = down_last_q;
`ifdef PARITY_ACC_EN
        acc_d         = acc_q;
        if (adv) begin
            down_valid_d = 1'b0;
            if (tree_vld) begin
                if (tree_lst) begin
                    down_valid_d  = 1'b1;
                    down_parity_d = odd_out;
                    down_last_d   = 1'b1;
                    acc_d         = 1'b0;
                end else begin
                    acc_d = acc_x;
                end
            end
        end
`else
        if (adv) begin
            down_valid_d = tree_vld;
            if (tree_vld) begin
                down_parity_d = odd_out;
                down_last_d   = tree_lst;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            down_valid_q  <= 1'b0;
            down_parity_q <= 1'b0;
            down_last_q   <= 1'b0;
`ifdef PARITY_ACC_EN
            acc_q         <= 1'b0;
`endif
        end else begin
            down_valid_q  <= down_valid_d;
            down_parity_q <= down_parity_d;
            down_last_q   <= down_last_d;
`ifdef PARITY_ACC_EN
            acc_q         <= acc_d;
`endif
        end
    end

    assign down_valid  = down_valid_q;
    assign down_parity = down_parity_q;
    assign down_last   = down_last_q;

endmodule

// File: tb/tb_xor_mux_parity_pipe.sv
// Testbench for xor_mux_parity_pipe. Two instances (ODD=0 and ODD=1) share
// all inputs. A negedge monitor pushes expected results on acceptance and
// pops/compares them when a result is handed off downstream.
module tb_xor_mux_parity_pipe;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_valid, up_last, down_ready;
    logic [W-1:0] up_data;
    logic         up_ready, down_valid, down_parity, down_last;
    logic         o_up_ready, o_down_valid, o_down_parity, o_down_last;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rx     = 0;
    int n_push   = 0;

    logic exp_q[$];
    logic exp_last_q[$];
    logic acc_m = 1'b0;

    always #5 clk = ~clk;

    xor_mux_parity_pipe #(.WIDTH(W), .ODD(0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .up_last     (up_last),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
        .down_parity (down_parity),
        .down_last   (down_last)
    );

    xor_mux_parity_pipe #(.WIDTH(W), .ODD(1)) u_dut_odd (
        .clk         (clk),
        .rst         (rst),
        .up_valid    (up_valid),
        .up_ready    (o_up_ready),
        .up_data     (up_data),
        .up_last     (up_last),
        .down_valid  (o_down_valid),
        .down_ready  (down_ready),
        .down_parity (o_down_parity),
        .down_last   (o_down_last)
    );

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic e, el;
        if (rst === 1'b1) begin
            exp_q.delete();
            exp_last_q.delete();
            acc_m = 1'b0;
        end else begin
            if (down_valid === 1'b1 && down_ready === 1'b1) begin
                n_rx++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_result: got parity=%0b last=%0b, required no result",
                             down_parity, down_last);
                end else begin
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (down_parity !== e || down_last !== el)
                        $display("FAIL result_even: got parity=%0b last=%0b, required parity=%0b last=%0b",
                                 down_parity, down_last, e, el);
                    else
                        n_pass++;
                    n_checks++;
                    if (o_down_valid !== 1'b1 || o_down_parity !== ~e || o_down_last !== el)
                        $display("FAIL result_odd: got valid=%0b parity=%0b last=%0b, required valid=1 parity=%0b last=%0b",
                                 o_down_valid, o_down_parity, o_down_last, ~e, el);
                    else
                        n_pass++;
                end
            end
            if (up_valid === 1'b1 && up_ready === 1'b1) begin
`ifdef PARITY_ACC_EN
                if (up_last) begin
                    exp_q.push_back(acc_m ^ (^up_data));
                    exp_last_q.push_back(1'b1);
                    acc_m = 1'b0;
                    n_push++;
                end else begin
                    acc_m = acc_m ^ (^up_data);
                end
`else
                exp_q.push_back(^up_data);
                exp_last_q.push_back(up_last);
                n_push++;
`endif
            end
        end
    end

    task automatic test_reset();
        rst        = 1'b1;
        up_valid   = 1'b1;
        up_data    = 8'hFF;
        up_last    = 1'b1;
        down_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({down_valid, down_parity, down_last, up_ready} !== 4'b0001)
            $display("FAIL reset_even: got v/p/l/rdy=%b, required 0001",
                     {down_valid, down_parity, down_last, up_ready});
        else n_pass++;
        n_checks++;
        if ({o_down_valid, o_down_parity, o_down_last, o_up_ready} !== 4'b0001)
            $display("FAIL reset_odd: got v/p/l/rdy=%b, required 0001",
                     {o_down_valid, o_down_parity, o_down_last, o_up_ready});
        else n_pass++;
        rst      = 1'b0;
        up_valid = 1'b0;
        up_last  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (down_valid !== 1'b0 || o_down_valid !== 1'b0)
                $display("FAIL reset_no_result: got valid=%0b/%0b, required 0/0",
                         down_valid, o_down_valid);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

`ifndef PARITY_ACC_EN
    task automatic test_stream();
        logic [7:0] words [4];
        logic       exp_v;
        words      = '{8'h00, 8'h01, 8'hFF, 8'hA7};
        down_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            up_valid = (i < 4);
            up_data  = 8'h00;
            if (i < 4) up_data = words[i];
            up_last  = (i % 2 == 1);
            @(negedge clk);
            exp_v = (i >= 4 && i < 8);
            n_checks++;
            if (down_valid !== exp_v)
                $display("FAIL stream_timing[%0d]: got valid=%0b, required %0b", i, down_valid, exp_v);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        up_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL stream_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask
`endif

    task automatic test_odd_values();
        int rx0;
        rx0        = n_rx;
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_last    = 1'b1;
        up_data    = 8'h03;
        @(posedge clk);
        #1;
        up_data = 8'h07;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (n_rx - rx0 != 2 || exp_q.size() != 0)
            $display("FAIL odd_count: got %0d results (%0d pending), required 2 (0)",
                     n_rx - rx0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int   sent, rx0, push0;
        logic stalled_prev, par_prev, last_prev, took;
        sent         = 0;
        rx0          = n_rx;
        push0        = n_push;
        stalled_prev = 1'b0;
        par_prev     = 1'b0;
        last_prev    = 1'b0;
        up_valid     = 1'b1;
        up_data      = 8'($urandom);
        up_last      = 1'($urandom);
        for (int cyc = 0; cyc < 100 && sent < 12; cyc++) begin
            down_ready = !(cyc >= 3 && cyc < 8);
            if (sent == 11) up_last = 1'b1;
            @(negedge clk);
            n_checks++;
            if (up_ready !== (!down_valid || down_ready))
                $display("FAIL bp_up_ready[%0d]: got %0b, required %0b",
                         cyc, up_ready, (!down_valid || down_ready));
            else n_pass++;
            if (down_valid === 1'b1 && down_ready === 1'b0) begin
                if (stalled_prev) begin
                    n_checks++;
                    if (down_parity !== par_prev || down_last !== last_prev)
                        $display("FAIL bp_stable[%0d]: got p/l=%0b%0b, required %0b%0b",
                                 cyc, down_parity, down_last, par_prev, last_prev);
                    else n_pass++;
                end
                stalled_prev = 1'b1;
                par_prev     = down_parity;
                last_prev    = down_last;
            end else begin
                stalled_prev = 1'b0;
            end
            took = up_valid && up_ready;
            @(posedge clk);
            #1;
            if (took) begin
                sent++;
                up_data = 8'($urandom);
                up_last = 1'($urandom);
            end
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sent != 12 || exp_q.size() != 0 || (n_rx - rx0) != (n_push - push0))
            $display("FAIL bp_count: got sent=%0d rx=%0d pending=%0d, required sent=12 rx=%0d pending=0",
                     sent, n_rx - rx0, exp_q.size(), n_push - push0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int rx0;
        rx0        = n_rx;
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_data    = 8'h01;
        up_last    = 1'b0;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        up_valid = 1'b1;
        up_data  = 8'h00;
        up_last  = 1'b1;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_last  = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (n_rx - rx0 != 1 || exp_q.size() != 0)
            $display("FAIL reset_mid_count: got %0d results (%0d pending), required 1 (0)",
                     n_rx - rx0, exp_q.size());
        else n_pass++;
    endtask

`ifdef PARITY_ACC_EN
    task automatic test_packet();
        logic [7:0] words [4];
        logic       lasts [4];
        int         rx0;
        words      = '{8'h01, 8'h03, 8'h01, 8'h80};
        lasts      = '{1'b0, 1'b0, 1'b1, 1'b1};
        rx0        = n_rx;
        down_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_valid = 1'b1;
            up_data  = words[i];
            up_last  = lasts[i];
            @(posedge clk);
            #1;
        end
        up_valid = 1'b0;
        up_last  = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (n_rx - rx0 != 2 || exp_q.size() != 0)
            $display("FAIL packet_count: got %0d results (%0d pending), required 2 (0)",
                     n_rx - rx0, exp_q.size());
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
`ifndef PARITY_ACC_EN
        test_stream();
`endif
        test_odd_values();
        test_backpressure();
        test_reset_mid();
`ifdef PARITY_ACC_EN
        test_packet();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
